// File: rtl/jtcop_paldma.sv
// Palette DMA: copies the whole shadow palette into the active palette RAM on request.
// Define JTCOP_PALDMA_BLANKONLY_EN to restrict writes to vertical blanking (pause/resume on LVBL).
module jtcop_paldma #(
   parameter int AW = 10,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          LVBL,
   input  logic          dma_req,
   output logic [AW-1:0] sh_addr,
   input  logic [DW-1:0] sh_dout,
   output logic [AW-1:0] pal_addr,
   output logic [DW-1:0] pal_data,
   output logic [1:0]    pal_we,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      PRIME,
      COPY
   } state_t;

   state_t        state, state_nx;
   logic [AW-1:0] rd_cnt, wr_cnt;
   logic          rearm;
   logic          blank;
   logic          write;
   logic          last;

`ifdef JTCOP_PALDMA_BLANKONLY_EN
   assign blank = ~LVBL;
`else
   logic unused_lvbl;
   assign unused_lvbl = LVBL;
   assign blank       = 1'b1;
`endif

   // A COPY cycle outside blanking writes nothing: the word read for it is simply dropped.
   assign write = (state == COPY) && blank;
   assign last  = (wr_cnt == {AW{1'b1}});

   assign busy     = (state != IDLE);
   assign sh_addr  = rd_cnt;
   assign pal_we   = {2{write}};
   assign pal_addr = write ? wr_cnt  : '0;
   assign pal_data = write ? sh_dout : '0;

   // NOTE: the next-state default is assigned first so no path through the case infers a latch.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (dma_req) state_nx = WAIT;
         WAIT:  if (blank)   state_nx = PRIME;
         PRIME: state_nx = COPY;
         COPY: begin
            if (!blank)
               state_nx = WAIT;
            else if (last)
               state_nx = (rearm || dma_req) ? WAIT : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
         rearm  <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= write && last;
         // Requests arriving mid-copy collapse into a single follow-on copy.
         if (busy) begin
            if (write && last)
               rearm <= 1'b0;
            else if (dma_req)
               rearm <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (dma_req) begin
                  rd_cnt <= '0;
                  wr_cnt <= '0;
               end
            end
            PRIME: rd_cnt <= rd_cnt + AW'(1);
            COPY: begin
               if (!blank) begin
                  // Rewind the read side to the first unwritten word for the next PRIME.
                  rd_cnt <= wr_cnt;
               end else if (last) begin
                  rd_cnt <= '0;
                  wr_cnt <= '0;
               end else begin
                  rd_cnt <= rd_cnt + AW'(1);
                  wr_cnt <= wr_cnt + AW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/jtcop_paldma.md
# jtcop_paldma

Palette DMA controller that owns the write port of the video palette RAM read by the colour mixer. CPU palette writes land in a shadow RAM. On a CPU trigger this block copies the whole shadow RAM into the active palette, and only while the screen is blanked, so no mid-frame colour tearing is visible. It sits between the shadow RAM read port and the palette RAM write port, running on the video clock.

## Interface
Parameters:
- AW, 10, palette address width; copy length is 2^AW words
- DW, 16, palette word width

Ports:
- clk  in  1  video clock
- rst_n  in  1  asynchronous active-low reset
- LVBL  in  1  vertical blank, active low (0 = blanking)
- dma_req  in  1  one-cycle copy request, already synchronised to clk
- sh_addr  out  AW  shadow RAM read address; read data is valid one clk later
- sh_dout  in  DW  shadow RAM read data
- pal_addr  out  AW  palette RAM write address
- pal_data  out  DW  palette RAM write data
- pal_we  out  2  byte write enables, always both set together
- busy  out  1  high from request acceptance until copy completion
- done  out  1  one-cycle pulse after the last word is written

## Operation
- Internal state: rd_cnt[AW-1:0] (next read address), wr_cnt[AW-1:0] (next write address), flag rearm.
- IDLE
  - dma_req -> WAIT.
  - On entry to WAIT, rd_cnt = wr_cnt = 0 and busy = 1.
- WAIT
  - LVBL == 0 -> PRIME.
  - LVBL == 1 -> stay.
- PRIME (1 cycle)
  - sh_addr = rd_cnt, then rd_cnt += 1.
  - -> COPY.
- COPY, each cycle with LVBL == 0:
  - pal_we = 2'b11, pal_addr = wr_cnt, pal_data = sh_dout.
  - wr_cnt += 1.
  - sh_addr = rd_cnt, then rd_cnt += 1.
- End of copy, on the write with wr_cnt == 2^AW-1:
  - Next cycle done = 1.
  - If rearm: rearm = 0, reset counters, -> WAIT with busy held high.
  - Otherwise: busy = 0, -> IDLE.
- LVBL rises during COPY (pause):
  - pal_we = 0 in that same cycle; the in-flight read is discarded.
  - rd_cnt = wr_cnt.
  - -> WAIT, so the copy resumes at the first unwritten word in the next vblank, through PRIME.
- rd_cnt wraps modulo 2^AW. The one-ahead read past the last word is harmless and ignored.
- dma_req while busy sets rearm, so a second full copy follows. Multiple requests collapse into one.
- dma_req on the done cycle also sets rearm.
- sh_addr is a registered output, so RAM data lines up with the following write cycle.

## Timing
- Reset values: pal_we = 0, pal_addr = 0, pal_data = 0, sh_addr = 0, busy = 0, done = 0, state IDLE, rearm = 0. Assertion is asynchronous and takes effect mid-copy; no further writes follow.
- busy rises the cycle after dma_req.
- Uninterrupted copy: 1 PRIME cycle + 2^AW write cycles. done pulses the cycle after the last write.
- Throughput: one word per clk during COPY.
- Resume after pause: first write 2 cycles after LVBL falls (WAIT→PRIME, PRIME→COPY).
- pal_we is never high while LVBL == 1 in the same cycle, under JTCOP_PALDMA_BLANKONLY_EN.

## Configuration
- JTCOP_PALDMA_BLANKONLY_EN defined:
  - Behaviour as above; writes happen only while LVBL == 0.
  - Pause and resume are active.
- JTCOP_PALDMA_BLANKONLY_EN undefined:
  - LVBL is ignored. WAIT moves to PRIME immediately and COPY never pauses.
  - Total latency from dma_req to done is 2^AW + 3 cycles.
  - Intended for fast simulation and for games that are immune to tearing.

## Test plan
- Reset: hold rst_n = 0 mid-COPY -> pal_we = 0, busy = 0 and all outputs 0 in the same cycle; after release there are no writes until the next dma_req.
- Full copy, AW = 10, LVBL = 0 throughout, shadow[i] = i ^ 16'hA5A5 -> 1024 writes with pal_addr = i and pal_data = i ^ 16'hA5A5 on consecutive cycles; done pulses once, 1 cycle after the write to 0x3FF.
- Request during active video: dma_req with LVBL = 1 for 50 cycles -> busy = 1 and no writes; first write at address 0 exactly 2 cycles after LVBL falls.
- Pause and resume: LVBL rises after 300 writes (0..0x12B) -> pal_we = 0 that cycle; next vblank resumes at 0x12C with correct data; no address is written twice and none is skipped.
- Re-arm: three dma_req pulses during a copy -> exactly one extra full copy (2048 writes total, two done pulses); busy stays high between the copies.
- Macro undefined: LVBL toggling every 100 cycles -> 1024 writes uninterrupted; done at dma_req + 1027 cycles.
